// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter with saturation
// Optional leading-zero blanking mask built only when BIN2BCD_LZB_EN is defined.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf,
  output logic [DIGITS-1:0]   blank
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + 1;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned BCD_MAX = pow10(DIGITS) - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_next;
  logic [WORK_W-1:0]   work, work_next;
  logic [BCD_W-1:0]    work_adj;
  logic [BIN_W-1:0]    bin_sr;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_pend;
  logic                accept, finish, last, sat;
  logic [BCD_W-1:0]    result;

  assign last = (cnt == CNT_W'(BIN_W - 1));
  assign busy = (state == SHIFT);

  // Add-3 on every nibble in parallel, then shift one input bit in.
  // The top bit is sticky so a carry out of the last digit can never be lost.
  always_comb begin
    work_adj = work[BCD_W-1:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
    work_next = {work_adj, bin_sr[BIN_W-1]};
    work_next[WORK_W-1] = work_next[WORK_W-1] | work[WORK_W-1];
    sat    = ovf_pend | work_next[WORK_W-1];
    result = sat ? {DIGITS{4'h9}} : work_next[BCD_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work     <= '0;
      bin_sr   <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        bin_sr   <= bin;
        work     <= '0;
        cnt      <= '0;
        ovf_pend <= (32'(bin) > BCD_MAX);
      end else if (state == SHIFT) begin
        work   <= work_next;
        bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
        cnt    <= cnt + CNT_W'(1);
      end
      if (finish) begin
        bcd <= result;
        ovf <= sat;
      end
    end
  end

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] blank_next, blank_q;
  logic              zero_run;

  // The rightmost digit always shows, so the run stops at digit index 1.
  always_comb begin
    blank_next = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (result[4*i +: 4] == 4'd0);
      blank_next[i] = zero_run;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    else if (finish) blank_q <= blank_next;
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - table and scoreboard bench for bin2bcd_seq
module tb_bin2bcd_seq;

`ifdef BIN2BCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic        busy, done, ovf;
  logic [15:0] bcd;
  logic [3:0]  blank;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .blank(blank)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
  } res_t;

  typedef struct {
    int   bin;
    res_t exp;
  } vec_t;

  res_t        sb[$];
  vec_t        vecs[10];
  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic        saw_done = 1'b0;
  logic [15:0] held_bcd = '0;
  logic [3:0]  rst_blank;

  function automatic res_t mk(input logic [15:0] b, input logic o, input logic [3:0] bl);
    res_t r;
    r.bcd   = b;
    r.ovf   = o;
    r.blank = LZB ? bl : 4'b0000;
    return r;
  endfunction

  // Independent reference: decimal digit extraction by division.
  function automatic res_t model(input int v);
    int d[4];
    logic [3:0] bl;
    if (v > 9999) return mk(16'h9999, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) d[i] = (v / (10 ** i)) % 10;
    bl[3] = (d[3] == 0);
    bl[2] = bl[3] && (d[2] == 0);
    bl[1] = bl[2] && (d[1] == 0);
    bl[0] = 1'b0;
    return mk({4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])}, 1'b0, bl);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    res_t e;
    @(negedge clk);
    saw_done = done;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("bcd", 32'(bcd), 32'(e.bcd));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("blank", 32'(blank), 32'(e.blank));
        held_bcd = e.bcd;
      end
    end
  endtask

  task automatic issue(input int v);
    start = 1'b1;
    bin   = 14'(v);
    sb.push_back(model(v));
    check("bcd_hold", 32'(bcd), 32'(held_bcd));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, input int busy0);
    int lat, busy_n;
    lat    = lat0;
    busy_n = busy0;
    while (!saw_done && lat < 40) begin
      tick();
      lat++;
      if (busy) busy_n++;
    end
    check("done_seen", 32'(saw_done), 32'd1);
    check("latency", 32'(lat), 32'd14);
    check("busy_cycles", 32'(busy_n), 32'd14);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_bcd"}, 32'(bcd), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_blank"}, 32'(blank), 32'(rst_blank));
  endtask

  initial begin
    int base;
    rst_blank = LZB ? 4'b1110 : 4'b0000;

    vecs[0] = '{1234,  mk(16'h1234, 1'b0, 4'b0000)};
    vecs[1] = '{10000, mk(16'h9999, 1'b1, 4'b0000)};
    vecs[2] = '{16383, mk(16'h9999, 1'b1, 4'b0000)};
    vecs[3] = '{42,    mk(16'h0042, 1'b0, 4'b1100)};
    vecs[4] = '{0,     mk(16'h0000, 1'b0, 4'b1110)};
    vecs[5] = '{9999,  mk(16'h9999, 1'b0, 4'b0000)};
    vecs[6] = '{1,     mk(16'h0001, 1'b0, 4'b1110)};
    vecs[7] = '{100,   mk(16'h0100, 1'b0, 4'b1000)};
    vecs[8] = '{9000,  mk(16'h9000, 1'b0, 4'b0000)};
    vecs[9] = '{305,   mk(16'h0305, 1'b0, 4'b1000)};

    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    repeat (3) tick();
    check_reset("idle");

    // Table: the model must agree with the hand-written constants, and the DUT with both.
    foreach (vecs[i]) begin
      check("model_table", 32'(model(vecs[i].bin)), 32'(vecs[i].exp));
      issue(vecs[i].bin);
      wait_done(0, 1);
      tick();
      check("done_pulse", 32'(done), 32'd0);
    end

    for (int i = 0; i < 6; i++) begin
      issue(int'($urandom_range(16383)));
      wait_done(0, 1);
    end

    // Back-to-back: second start rides the done cycle.
    issue(9999);
    wait_done(0, 1);
    issue(0);
    wait_done(0, 1);

    // Start while busy is ignored.
    base = done_cnt;
    issue(500);
    repeat (3) tick();
    start = 1'b1;
    bin   = 14'd7;
    tick();
    start = 1'b0;
    wait_done(4, 5);
    repeat (20) tick();
    check("single_done", 32'(done_cnt - base), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-conversion aborts it.
    issue(4321);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check_reset("async");
    sb.delete();
    held_bcd = '0;
    tick();
    tick();
    rst  = 1'b0;
    base = done_cnt;
    repeat (20) tick();
    check("no_done_after_abort", 32'(done_cnt - base), 32'd0);
    issue(88);
    wait_done(0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly upstream of display_driver. It accepts a binary value on a start strobe and produces four packed BCD digits for the dig1..dig4 positions. Outputs are registered and held stable between conversions, so the display multiplexer always reads a coherent value. Saturates out-of-range inputs and flags them.

Parameters:
BIN_W, 14, width of binary input; must satisfy 2^BIN_W - 1 <= 16383.
DIGITS, 4, number of BCD output digits; fixed at 4 for display_driver, kept as a parameter for range and saturation math.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous active-high reset.
start  input  1  request conversion of bin; accepted only when busy=0.
bin  input  BIN_W  unsigned binary value, sampled on the accepting edge.
busy  output  1  conversion in progress.
done  output  1  one-cycle pulse; bcd/ovf valid and updated in the same cycle.
bcd  output  4*DIGITS  packed BCD. [15:12] maps to dig1 (leftmost), [3:0] maps to dig4.
ovf  output  1  last accepted bin exceeded 10^DIGITS-1 (9999).
blank  output  DIGITS  leading-zero blank mask, bit3=dig1 (only with BIN2BCD_LZB_EN).

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, bcd=0x0000, ovf=0, blank=4'b1110. Shift registers and counter cleared. A conversion in flight is aborted, and no done is issued for it.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge E0:
  - latch bin into the shift register and clear the working BCD register;
  - set ovf_pend = (bin > 9999) and cnt=0;
  - go to SHIFT with busy=1.
- IDLE, start=0: hold all outputs; done=0.
- SHIFT, each edge:
  - every working BCD nibble >= 5 gets +3 (combinational, all nibbles in parallel);
  - then shift the {bcd_work, bin_sr} concatenation left by 1;
  - cnt++.
- On the edge where cnt reaches BIN_W-1 (edge E_BIN_W):
  - bcd <= the final shifted value, or 0x9999 if ovf_pend;
  - ovf <= ovf_pend; done <= 1; busy <= 0; state -> IDLE.
- Latency: done is high in the cycle immediately after edge E0+BIN_W (14 clocks for the default). busy is high for exactly BIN_W cycles.
- done is high for exactly one cycle. It is cleared on the next edge unless a new conversion completes then, which is impossible since the minimum spacing is BIN_W.
- start while busy=1: ignored, with no queuing and no effect on the current conversion.
- start in the done cycle: busy=0, so it is accepted. Back-to-back conversions are allowed with zero idle cycles.
- bcd, ovf and blank change only in the done cycle or on reset. They are never partially updated.
- Working nibbles never exceed 9 after correction. Internal width is 4*DIGITS+1 bits, so the top-digit carry is kept for overflow safety.
- No combinational path from inputs to outputs.

Optional Feature:
BIN2BCD_LZB_EN:
- Defined: blank is registered in the done cycle. blank[i]=1 when digit i and all more-significant digits are zero, except dig4 (blank[0]), which is never blanked. Examples: 0 -> 4'b1110; 42 -> 4'b1100; 1234 -> 4'b0000. On overflow, blank=4'b0000.
- Not defined: the blank port is still present but tied to 4'b0000. No extra registers are built.

Test Plan:
1. rst pulse then idle -> busy=0, done=0, bcd=0x0000, ovf=0, blank=1110 (LZB on) / 0000 (LZB off).
2. start with bin=1234 -> busy high 14 cycles; done pulse 14 clocks after the accepting edge; bcd=0x1234, ovf=0, blank=0000.
3. Back-to-back: start with bin=9999, then start with bin=0 asserted in the done cycle -> first done gives bcd=0x9999 and ovf=0; second done, 14 cycles later, gives bcd=0x0000, ovf=0, blank=1110.
4. bin=10000, then bin=16383 -> bcd=0x9999, ovf=1 each time. A following bin=42 -> bcd=0x0042, ovf=0, blank=1100.
5. start with bin=500, then pulse start with bin=7 at cycle 5 of busy -> the second start is ignored; a single done with bcd=0x0500.
6. start with bin=4321, assert rst at cycle 7 of busy -> outputs return to reset values immediately (async); no done follows; a subsequent start with bin=88 yields 0x0088 normally.
